rsa_key_builder: RTL and testbench
==================================

// Module: rsa_key_builder
// PURPOSE
// - Initiator/consumer side of the prime generator start/done handshake.
// - Requests a prime pair (P, Q), latches it, and computes N = P*Q and phi = (P-1)*(Q-1).
// - Checks gcd(E, phi) == 1 and re-requests primes on failure.
// - Sits between the prime generator and the RSA exponent/keying logic.
// PARAMETERS
// - WORD_WIDTH   32  width of P, Q, E; N and phi are 2*WORD_WIDTH
// - MAX_RETRIES  8   rejected pairs tolerated before abort (used only with KEY_RETRY_LIMIT_EN)
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      asynchronous, active-high reset
// - start      in   1      begin key build; sampled only in IDLE
// - e          in   WW     public exponent, latched when start is accepted
// - busy       out  1      high from start acceptance until the done cycle, inclusive
// - done       out  1      one-cycle completion pulse
// - key_valid  out  1      n/phi valid and gcd(e,phi)==1; held until next accepted start
// - error      out  1      retry limit hit; held until next accepted start
// - n          out  2*WW   P*Q
// - phi        out  2*WW   (P-1)*(Q-1)
// - retries    out  8      rejected pairs this build, saturating at 255
// - pg_start   out  1      one-cycle request pulse to the prime generator
// - pg_done    in   1      generator completion pulse; pg_p/pg_q valid in this cycle
// - pg_p       in   WW     prime P
// - pg_q       in   WW     prime Q
// BEHAVIOUR
// - Reset state: all outputs 0, FSM in IDLE. Reset mid-operation returns to IDLE
//   immediately and drops pg_start. Any in-flight generator result is later ignored.
// - States: IDLE, CHECK_E, REQ, WAIT_PG, MUL, GCD, DONE.
// - IDLE
//   - start=1: latch e; clear retries, key_valid, error; busy=1; go to CHECK_E.
// - CHECK_E
//   - If e<3 or e even: go to DONE with key_valid=0. pg_start is never issued.
//   - Otherwise go to REQ.
// - REQ: pg_start=1 for exactly this cycle; go to WAIT_PG.
// - WAIT_PG
//   - Hold until pg_done=1, then latch pg_p and pg_q in that same cycle.
//   - No timeout.
// - MUL: two parallel shift-add multipliers (P*Q, (P-1)*(Q-1)).
//   - One multiplier bit per cycle, exactly WORD_WIDTH cycles.
//   - Products are full 2*WW width; no truncation.
// - GCD: binary (Stein) gcd of a = zero-extended e and b = phi.
//   - e is odd, so common powers of two are never extracted.
//   - One operation per cycle: if b even, b >>= 1.
//   - Else if a > b, swap a and b.
//   - Else b = b - a.
//   - Finish when b == 0; bounded by 4*2*WW cycles.
//   - a==1: n/phi registered, key_valid=1, go to DONE.
//   - a!=1: retries++ (saturating), go to REQ.
// - DONE: done=1 and busy=1 for one cycle; go to IDLE.
// - start while busy is ignored; pg_done outside WAIT_PG is ignored.
// - n/phi update only on success; they are cleared at start acceptance.
// - Latency: 2 + generator latency + WW + gcd cycles + 1 per attempt.
// CONFIGURATION
// - KEY_RETRY_LIMIT_EN defined
//   - A gcd failure with retries == MAX_RETRIES goes to DONE with error=1, key_valid=0.
//   - Total attempts are therefore MAX_RETRIES+1.
// - KEY_RETRY_LIMIT_EN undefined
//   - Retries are unbounded; error is tied 0.
//   - MAX_RETRIES is unused.
// TESTING
// - Bench setup: WORD_WIDTH=8, behavioural generator stub returning a scripted P/Q list
//   after 5 cycles.
// - Basic build: e=17, stub P=61 Q=53
//   - Response: one pg_start; n=3233, phi=3120, key_valid=1, retries=0.
//   - done pulses once.
// - Retry: e=3, stub (7,11) then (5,17)
//   - (7,11) gives phi=60, gcd 3, rejected.
//   - Response: two pg_start pulses; n=85, phi=64, key_valid=1, retries=1.
// - Bad exponent: e=4
//   - Response: done within 3 cycles of start, key_valid=0, pg_start never high.
// - Busy/ignore: second start during WAIT_PG, and a spurious pg_done during MUL
//   - Response: no effect on the result of the basic build.
// - Reset mid-MUL: assert rst
//   - Response: same cycle, all outputs 0.
//   - After release, a new start completes the basic build correctly.
// - KEY_RETRY_LIMIT_EN, MAX_RETRIES=2: e=3, stub always (7,13), phi=72
//   - Response: three pg_start pulses, done with error=1, key_valid=0, retries=2.

Source files
------------

// File: rtl/rsa_key_builder.sv
// rsa_key_builder: requests a prime pair from the prime generator, forms
// n = P*Q and phi = (P-1)*(Q-1) with shift-add multipliers, then runs a binary
// gcd of e against phi and re-requests primes whenever gcd(e, phi) != 1.
// Optional build macro KEY_RETRY_LIMIT_EN: abort with error after MAX_RETRIES
// rejected pairs; without it retries are unbounded and error stays 0.
module rsa_key_builder #(
    parameter int WORD_WIDTH  = 32,
    parameter int MAX_RETRIES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   e,
    output logic                    busy,
    output logic                    done,
    output logic                    key_valid,
    output logic                    error,
    output logic [2*WORD_WIDTH-1:0] n,
    output logic [2*WORD_WIDTH-1:0] phi,
    output logic [7:0]              retries,
    output logic                    pg_start,
    input  logic                    pg_done,
    input  logic [WORD_WIDTH-1:0]   pg_p,
    input  logic [WORD_WIDTH-1:0]   pg_q
);

    localparam int PW    = 2 * WORD_WIDTH;
    localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

`ifdef KEY_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CHECK_E,
        REQ,
        WAIT_PG,
        MUL,
        GCD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD_WIDTH-1:0] e_reg;
    logic [WORD_WIDTH-1:0] mplier_n;
    logic [WORD_WIDTH-1:0] mplier_phi;
    logic [PW-1:0]         mcand_n;
    logic [PW-1:0]         mcand_phi;
    logic [PW-1:0]         acc_n;
    logic [PW-1:0]         acc_phi;
    logic [PW-1:0]         acc_n_next;
    logic [PW-1:0]         acc_phi_next;
    logic [PW-1:0]         gcd_a;
    logic [PW-1:0]         gcd_b;
    logic [CNT_W-1:0]      bit_cnt;

    logic e_bad;
    logic mul_last;
    logic gcd_finished;
    logic gcd_coprime;
    logic limit_hit;

    // Shared decision terms used by both the FSM and the datapath
    always_comb begin
        e_bad        = (e_reg < WORD_WIDTH'(3)) || !e_reg[0];
        mul_last     = (bit_cnt == CNT_W'(WORD_WIDTH - 1));
        acc_n_next   = acc_n + (mplier_n[0] ? mcand_n : '0);
        acc_phi_next = acc_phi + (mplier_phi[0] ? mcand_phi : '0);
        gcd_finished = (gcd_b == '0);
        gcd_coprime  = (gcd_a == PW'(1));
        limit_hit    = LIMIT_EN && (retries == 8'(MAX_RETRIES));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK_E;
            CHECK_E: state_next = e_bad ? DONE : REQ;
            REQ:     state_next = WAIT_PG;
            WAIT_PG: if (pg_done) state_next = MUL;
            MUL:     if (mul_last) state_next = GCD;
            GCD: begin
                if (gcd_finished) begin
                    if (gcd_coprime || limit_hit) begin
                        state_next = DONE;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        pg_start = (state == REQ);
    end

    // Operand latching, multipliers, gcd iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_reg      <= '0;
            mplier_n   <= '0;
            mplier_phi <= '0;
            mcand_n    <= '0;
            mcand_phi  <= '0;
            acc_n      <= '0;
            acc_phi    <= '0;
            gcd_a      <= '0;
            gcd_b      <= '0;
            bit_cnt    <= '0;
            n          <= '0;
            phi        <= '0;
            retries    <= '0;
            key_valid  <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        e_reg     <= e;
                        retries   <= '0;
                        key_valid <= 1'b0;
                        error     <= 1'b0;
                        n         <= '0;
                        phi       <= '0;
                    end
                end
                WAIT_PG: begin
                    if (pg_done) begin
                        mcand_n    <= PW'(pg_p);
                        mcand_phi  <= PW'(pg_p - WORD_WIDTH'(1));
                        mplier_n   <= pg_q;
                        mplier_phi <= pg_q - WORD_WIDTH'(1);
                        acc_n      <= '0;
                        acc_phi    <= '0;
                        bit_cnt    <= '0;
                    end
                end
                MUL: begin
                    acc_n      <= acc_n_next;
                    acc_phi    <= acc_phi_next;
                    mcand_n    <= mcand_n << 1;
                    mcand_phi  <= mcand_phi << 1;
                    mplier_n   <= mplier_n >> 1;
                    mplier_phi <= mplier_phi >> 1;
                    bit_cnt    <= bit_cnt + CNT_W'(1);
                    if (mul_last) begin
                        gcd_a <= PW'(e_reg);
                        gcd_b <= acc_phi_next;
                    end
                end
                GCD: begin
                    if (gcd_finished) begin
                        if (gcd_coprime) begin
                            n         <= acc_n;
                            phi       <= acc_phi;
                            key_valid <= 1'b1;
                        end else if (limit_hit) begin
                            error <= 1'b1;
                        end else if (retries != 8'hFF) begin
                            retries <= retries + 8'd1;
                        end
                    end else if (!gcd_b[0]) begin
                        gcd_b <= gcd_b >> 1;
                    end else if (gcd_a > gcd_b) begin
                        gcd_a <= gcd_b;
                        gcd_b <= gcd_a;
                    end else begin
                        gcd_b <= gcd_b - gcd_a;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_key_builder.sv
// tb_rsa_key_builder: table-driven bench for rsa_key_builder at WORD_WIDTH=8
// with a scripted prime generator stub that answers 5 cycles after pg_start.
// Build with KEY_RETRY_LIMIT_EN to exercise the retry-limit abort path.
module tb_rsa_key_builder;

    localparam int WW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [WW-1:0] e;
    logic          busy;
    logic          done;
    logic          key_valid;
    logic          error;
    logic [2*WW-1:0] n;
    logic [2*WW-1:0] phi;
    logic [7:0]    retries;
    logic          pg_start;
    logic          pg_done;
    logic [WW-1:0] pg_p;
    logic [WW-1:0] pg_q;

    rsa_key_builder #(
        .WORD_WIDTH (WW),
        .MAX_RETRIES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .e        (e),
        .busy     (busy),
        .done     (done),
        .key_valid(key_valid),
        .error    (error),
        .n        (n),
        .phi      (phi),
        .retries  (retries),
        .pg_start (pg_start),
        .pg_done  (pg_done),
        .pg_p     (pg_p),
        .pg_q     (pg_q)
    );

    typedef struct {
        logic [7:0]      e;
        int              npairs;
        logic [3:0][7:0] p;
        logic [3:0][7:0] q;
        bit              poke;
        bit              fast;
        logic [15:0]     exp_n;
        logic [15:0]     exp_phi;
        bit              exp_kv;
        bit              exp_err;
        logic [7:0]      exp_retries;
        int              exp_pgs;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs[NVEC];

    int check_count = 0;
    int pass_count  = 0;

    logic [3:0][7:0] script_p;
    logic [3:0][7:0] script_q;
    int  script_len    = 1;
    int  script_base   = 0;
    bit  spurious_en   = 1'b0;
    int  deliver_count = 0;
    int  pg_start_count = 0;
    int  done_count    = 0;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Prime generator stub: answers each pg_start after 5 cycles from the script,
    // optionally followed by a spurious pg_done while the multipliers run
    initial begin
        int pend;
        int spur;
        int idx;
        pend = 0;
        spur = 0;
        pg_done = 1'b0;
        pg_p = '0;
        pg_q = '0;
        forever begin
            @(negedge clk);
            pg_done = 1'b0;
            if (spur > 0) begin
                spur--;
                if (spur == 0) begin
                    pg_done = 1'b1;
                    pg_p = 8'd255;
                    pg_q = 8'd255;
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    idx = deliver_count - script_base;
                    if (idx >= script_len) idx = script_len - 1;
                    pg_p = script_p[idx];
                    pg_q = script_q[idx];
                    pg_done = 1'b1;
                    deliver_count++;
                    if (spurious_en) spur = 3;
                end
            end
            if (pg_start) begin
                pend = 5;
                pg_start_count++;
            end
        end
    end

    // Done pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_count++;
        end
    end

    // Compare one value and tally the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic [7:0] ev, input int np,
                                   input logic [31:0] ps, input logic [31:0] qs,
                                   input bit poke, input bit fast,
                                   input logic [15:0] en, input logic [15:0] ephi,
                                   input bit kv, input bit err,
                                   input logic [7:0] r, input int pgs);
        vec_t v;
        v.e = ev;
        v.npairs = np;
        v.p = ps;
        v.q = qs;
        v.poke = poke;
        v.fast = fast;
        v.exp_n = en;
        v.exp_phi = ephi;
        v.exp_kv = kv;
        v.exp_err = err;
        v.exp_retries = r;
        v.exp_pgs = pgs;
        return v;
    endfunction

    // Run one complete key build from a table entry and check the results
    task automatic applyStimulus(input string tag, input vec_t v);
        int  cyc;
        bit  got;
        int  pgs0;
        int  d0;
        script_p    = v.p;
        script_q    = v.q;
        script_len  = v.npairs;
        script_base = deliver_count;
        spurious_en = v.poke;
        pgs0 = pg_start_count;
        d0   = done_count;
        e     = v.e;
        start = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (v.poke && cyc == 4);
            if (cyc == 4) e = 8'd9;
            if (cyc == 1) checkOutput({tag, "_busy_on"}, 32'(busy), 32'd1);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        checkOutput({tag, "_done_seen"}, 32'(got), 32'd1);
        if (v.fast) checkOutput({tag, "_fast_done"}, 32'(cyc <= 3), 32'd1);
        @(negedge clk);
        @(negedge clk);
        spurious_en = 1'b0;
        checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
        checkOutput({tag, "_n"}, 32'(n), 32'(v.exp_n));
        checkOutput({tag, "_phi"}, 32'(phi), 32'(v.exp_phi));
        checkOutput({tag, "_key_valid"}, 32'(key_valid), 32'(v.exp_kv));
        checkOutput({tag, "_error"}, 32'(error), 32'(v.exp_err));
        checkOutput({tag, "_retries"}, 32'(retries), 32'(v.exp_retries));
        checkOutput({tag, "_pg_starts"}, 32'(pg_start_count - pgs0), 32'(v.exp_pgs));
        checkOutput({tag, "_done_pulses"}, 32'(done_count - d0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Check that every output is at its reset value
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_n"}, 32'(n), 32'd0);
        checkOutput({tag, "_phi"}, 32'(phi), 32'd0);
        checkOutput({tag, "_retries"}, 32'(retries), 32'd0);
        checkOutput({tag, "_pg_start"}, 32'(pg_start), 32'd0);
    endtask

    // Main sequence: reset, table of builds, reset during multiply, rebuild
    initial begin
        int cyc;
        vecs[0] = mkVec(8'd17, 1, {8'd0, 8'd0, 8'd0, 8'd61}, {8'd0, 8'd0, 8'd0, 8'd53},
                        1'b0, 1'b0, 16'd3233, 16'd3120, 1'b1, 1'b0, 8'd0, 1);
        vecs[1] = mkVec(8'd3, 2, {8'd0, 8'd0, 8'd5, 8'd7}, {8'd0, 8'd0, 8'd17, 8'd11},
                        1'b0, 1'b0, 16'd85, 16'd64, 1'b1, 1'b0, 8'd1, 2);
        vecs[2] = mkVec(8'd4, 1, {8'd0, 8'd0, 8'd0, 8'd61}, {8'd0, 8'd0, 8'd0, 8'd53},
                        1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 8'd0, 0);
        vecs[3] = mkVec(8'd1, 1, {8'd0, 8'd0, 8'd0, 8'd61}, {8'd0, 8'd0, 8'd0, 8'd53},
                        1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 8'd0, 0);
        vecs[4] = mkVec(8'd2, 1, {8'd0, 8'd0, 8'd0, 8'd61}, {8'd0, 8'd0, 8'd0, 8'd53},
                        1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 8'd0, 0);
        vecs[5] = mkVec(8'd7, 1, {8'd0, 8'd0, 8'd0, 8'd251}, {8'd0, 8'd0, 8'd0, 8'd241},
                        1'b0, 1'b0, 16'd60491, 16'd60000, 1'b1, 1'b0, 8'd0, 1);
        vecs[6] = mkVec(8'd17, 1, {8'd0, 8'd0, 8'd0, 8'd61}, {8'd0, 8'd0, 8'd0, 8'd53},
                        1'b1, 1'b0, 16'd3233, 16'd3120, 1'b1, 1'b0, 8'd0, 1);
`ifdef KEY_RETRY_LIMIT_EN
        vecs[7] = mkVec(8'd3, 1, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd13},
                        1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 8'd2, 3);
`else
        vecs[7] = mkVec(8'd3, 4, {8'd5, 8'd7, 8'd7, 8'd7}, {8'd17, 8'd13, 8'd13, 8'd13},
                        1'b0, 1'b0, 16'd85, 16'd64, 1'b1, 1'b0, 8'd3, 4);
`endif

        rst   = 1'b1;
        start = 1'b0;
        e     = '0;
        script_p = '0;
        script_q = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus($sformatf("v%0d", i), vecs[i]);
        end

        script_p    = vecs[0].p;
        script_q    = vecs[0].q;
        script_len  = 1;
        script_base = deliver_count;
        e     = 8'd17;
        start = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        checkOutput("midmul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkResetOutputs("midmul_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        applyStimulus("post_reset", vecs[0]);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
